// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared constants and types for the data memory responder
// Purpose: MMIO offsets, CTRL bit positions, default MMIO base and the address-region type.
// Ports: none (package).
package data_mem_responder_pkg;

  localparam int          WW_DEFAULT        = 16;
  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

  // MMIO register offsets (addr[7:0] within the MMIO page)
  localparam logic [7:0] OFS_CNT    = 8'h00;
  localparam logic [7:0] OFS_CMP    = 8'h01;
  localparam logic [7:0] OFS_CTRL   = 8'h02;
  localparam logic [7:0] OFS_TXDATA = 8'h03;

  // CTRL register bit positions
  localparam int CTRL_CMPEN   = 0;
  localparam int CTRL_IRQ     = 1;
  localparam int CTRL_FULL    = 2;
  localparam int CTRL_EMPTY   = 3;
  localparam int CTRL_LVL_LSB = 4;
  localparam int CTRL_OVF     = 8;

  typedef enum logic [1:0] {
    REGION_HOLE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU data port and TX stream bundle for the responder
// Purpose: groups the CPU data-port signals plus the TX byte stream and IRQ line.
// Ports (master = CPU/consumer side, slave = responder):
//   mem_write_flag/addr/data, mem_read_addr : master -> slave
//   mem_read_data, tx_valid, tx_data, irq_flag : slave -> master
//   tx_ready : master -> slave
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_WIDTH = WW_DEFAULT
);
  logic                  mem_write_flag;
  logic [WORD_WIDTH-1:0] mem_write_addr;
  logic [WORD_WIDTH-1:0] mem_write_data;
  logic [WORD_WIDTH-1:0] mem_read_addr;
  logic [WORD_WIDTH-1:0] mem_read_data;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  irq_flag;

  modport master (
    output mem_write_flag, mem_write_addr, mem_write_data, mem_read_addr, tx_ready,
    input  mem_read_data, tx_valid, tx_data, irq_flag
  );

  modport slave (
    input  mem_write_flag, mem_write_addr, mem_write_data, mem_read_addr, tx_ready,
    output mem_read_data, tx_valid, tx_data, irq_flag
  );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// rtl/data_mem_responder_tx_fifo.sv - circular TX byte FIFO with overflow pulse
// Purpose: DEPTH-entry byte queue; head is presented combinationally from storage.
// Ports:
//   i_clk, i_rst        clock, async active-high reset (discards contents)
//   i_push, i_push_data push request and byte
//   i_pop               consumer ready; pop happens only when non-empty
//   o_valid, o_head     non-empty flag and head byte (0 when empty)
//   o_full, o_empty     level == DEPTH / level == 0
//   o_level             current entry count
//   o_ovf               one-cycle pulse when a push is dropped
module data_mem_responder_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [7:0]       i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [7:0]       o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic             o_ovf
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_pop;
  logic             w_push_ok;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_valid = ~o_empty;
  assign o_level = r_level;
  assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign w_pop     = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign o_ovf     = i_push & ~w_push_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; emptiness is tracked by the level counter alone.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-side responder for the CPU data port
// Purpose: decodes CPU data accesses to a local read-first RAM, an MMIO page
//   (cycle counter, compare/IRQ, control/status, TX FIFO) or an unmapped hole.
//   Read data returns with a fixed one-cycle latency and never stalls.
// Ports:
//   i_clk  system clock, all state on rising edge
//   i_rst  async active-high reset
//   bus    slave side of data_mem_responder_if (data port, TX stream, IRQ)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                    WORD_WIDTH     = WW_DEFAULT,
  parameter int                    RAM_ADDR_WIDTH = 10,
  parameter logic [WORD_WIDTH-1:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
  parameter int                    FIFO_DEPTH     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  data_mem_responder_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_WIDTH-1:0] w_wa, w_wd, w_ra;
  region_e               w_wr_region, w_rd_region, r_rd_region;
  logic                  w_ram_we, w_mmio_we, w_cnt_we, w_cmp_we, w_ctrl_we, w_tx_push;

  logic [WORD_WIDTH-1:0] r_ram [2**RAM_ADDR_WIDTH];
  logic [WORD_WIDTH-1:0] r_ram_q;
  logic [WORD_WIDTH-1:0] r_mmio_q;
  logic [WORD_WIDTH-1:0] r_cnt, r_cmp;
  logic                  r_cmp_en, r_irq, r_ovf;
  logic [WORD_WIDTH-1:0] w_ctrl_rdata, w_mmio_rdata;

  logic                  w_fifo_valid, w_fifo_full, w_fifo_empty, w_fifo_ovf;
  logic [7:0]            w_fifo_head;
  logic [LVL_W-1:0]      w_fifo_level;

  // RAM takes priority so that an odd MMIO_BASE can never shadow RAM.
  function automatic region_e decode(input logic [WORD_WIDTH-1:0] addr);
    if (addr[WORD_WIDTH-1:RAM_ADDR_WIDTH] == '0) return REGION_RAM;
    if (addr[WORD_WIDTH-1:8] == MMIO_BASE[WORD_WIDTH-1:8]) return REGION_MMIO;
    return REGION_HOLE;
  endfunction

  assign w_wa        = bus.mem_write_addr;
  assign w_wd        = bus.mem_write_data;
  assign w_ra        = bus.mem_read_addr;
  assign w_wr_region = decode(w_wa);
  assign w_rd_region = decode(w_ra);

  assign w_ram_we  = bus.mem_write_flag && (w_wr_region == REGION_RAM);
  assign w_mmio_we = bus.mem_write_flag && (w_wr_region == REGION_MMIO);
  assign w_cnt_we  = w_mmio_we && (w_wa[7:0] == OFS_CNT);
  assign w_cmp_we  = w_mmio_we && (w_wa[7:0] == OFS_CMP);
  assign w_ctrl_we = w_mmio_we && (w_wa[7:0] == OFS_CTRL);
  assign w_tx_push = w_mmio_we && (w_wa[7:0] == OFS_TXDATA);

  // Non-blocking write and read of the same word gives read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_ram[w_wa[RAM_ADDR_WIDTH-1:0]] <= w_wd;
    r_ram_q <= r_ram[w_ra[RAM_ADDR_WIDTH-1:0]];
  end

  data_mem_responder_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_tx_push),
    .i_push_data (w_wd[7:0]),
    .i_pop       (bus.tx_ready),
    .o_valid     (w_fifo_valid),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (w_fifo_level),
    .o_ovf       (w_fifo_ovf)
  );

  always_comb begin
    w_ctrl_rdata                           = '0;
    w_ctrl_rdata[CTRL_CMPEN]               = r_cmp_en;
    w_ctrl_rdata[CTRL_IRQ]                 = r_irq;
    w_ctrl_rdata[CTRL_FULL]                = w_fifo_full;
    w_ctrl_rdata[CTRL_EMPTY]               = w_fifo_empty;
    w_ctrl_rdata[CTRL_LVL_LSB +: 4]        = 4'(w_fifo_level);
    w_ctrl_rdata[CTRL_OVF]                 = r_ovf;
  end

  always_comb begin
    w_mmio_rdata = '0;
    if (w_rd_region == REGION_MMIO) begin
      case (w_ra[7:0])
        OFS_CNT:  w_mmio_rdata = r_cnt;
        OFS_CMP:  w_mmio_rdata = r_cmp;
        OFS_CTRL: w_mmio_rdata = w_ctrl_rdata;
        default:  w_mmio_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_cmp       <= '0;
      r_cmp_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_ovf       <= 1'b0;
      r_mmio_q    <= '0;
      r_rd_region <= REGION_HOLE;
    end else begin
      r_cnt <= w_cnt_we ? '0 : r_cnt + WORD_WIDTH'(1);
      if (w_cmp_we)  r_cmp    <= w_wd;
      if (w_ctrl_we) r_cmp_en <= w_wd[CTRL_CMPEN];
      // Set conditions beat a same-cycle write-one-to-clear.
      if (r_cmp_en && (r_cnt == r_cmp))       r_irq <= 1'b1;
      else if (w_ctrl_we && w_wd[CTRL_IRQ])   r_irq <= 1'b0;
      if (w_fifo_ovf)                         r_ovf <= 1'b1;
      else if (w_ctrl_we && w_wd[CTRL_OVF])   r_ovf <= 1'b0;
      r_mmio_q    <= w_mmio_rdata;
      r_rd_region <= w_rd_region;
    end
  end

  assign bus.mem_read_data = (r_rd_region == REGION_RAM) ? r_ram_q : r_mmio_q;
  assign bus.tx_valid      = w_fifo_valid;
  assign bus.tx_data       = w_fifo_head;
  assign bus.irq_flag      = r_irq;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WORD_WIDTH(16)) bus ();

  data_mem_responder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [1024];
  bit          m_known [1024];
  logic [15:0] m_cnt, m_cmp;
  bit          m_cmpen, m_irq, m_ovf;
  logic [7:0]  m_q [$];
  logic [15:0] m_rd;
  bit          m_rd_known;

  function automatic logic [15:0] model_read(input logic [15:0] a, output bit known);
    int sz;
    sz    = m_q.size();
    known = 1'b1;
    if (a < 16'd1024) begin
      known = m_known[a[9:0]];
      return m_ram[a[9:0]];
    end
    if (a == 16'hFF00) return m_cnt;
    if (a == 16'hFF01) return m_cmp;
    if (a == 16'hFF02)
      return {7'd0, m_ovf, 4'(sz), (sz == 0), (sz == 8), m_irq, m_cmpen};
    return 16'h0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit          wf, tr, pop, push, drop, irq_set;
    logic [15:0] wa, wd, ra;
    if (rst) begin
      m_cnt = 0; m_cmp = 0; m_cmpen = 0; m_irq = 0; m_ovf = 0;
      m_q.delete();
      m_rd = 0; m_rd_known = 1;
    end else begin
      wf = bus.mem_write_flag; wa = bus.mem_write_addr; wd = bus.mem_write_data;
      ra = bus.mem_read_addr;  tr = bus.tx_ready;
      m_rd    = model_read(ra, m_rd_known);
      pop     = tr && (m_q.size() > 0);
      push    = wf && (wa == 16'hFF03);
      drop    = push && (m_q.size() == 8) && !pop;
      irq_set = m_cmpen && (m_cnt == m_cmp);
      if (wf && wa < 16'd1024) begin
        m_ram[wa[9:0]] = wd; m_known[wa[9:0]] = 1;
      end
      if (wf && wa == 16'hFF01) m_cmp = wd;
      if (wf && wa == 16'hFF02) begin
        m_cmpen = wd[0];
        if (wd[1]) m_irq = 0;
        if (wd[8]) m_ovf = 0;
      end
      if (irq_set) m_irq = 1;
      if (drop)    m_ovf = 1;
      m_cnt = (wf && wa == 16'hFF00) ? 16'h0000 : m_cnt + 16'h0001;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(wd[7:0]);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_rd_known) check("rdata", bus.mem_read_data, m_rd);
    check("tx_valid", bus.tx_valid, m_q.size() != 0);
    check("tx_data", bus.tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("irq_flag", bus.irq_flag, m_irq);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic wf, input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
    bus.mem_write_flag = wf;
    bus.mem_write_addr = wa;
    bus.mem_write_data = wd;
    bus.mem_read_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.mem_write_flag = 0; bus.mem_write_addr = 0; bus.mem_write_data = 0;
    bus.mem_read_addr  = 0; bus.tx_ready = 0;
    #1 rst = 1;
    #20;
    check("reset_rdata", bus.mem_read_data, 16'h0000);
    check("reset_txvalid", bus.tx_valid, 1'b0);
    check("reset_irq", bus.irq_flag, 1'b0);
    @(posedge clk); #1 rst = 0;

    cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("cnt_first", bus.mem_read_data, 16'h0000);
    cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("cnt_second", bus.mem_read_data, 16'h0001);

    // RAM read-first
    cyc(1, 16'h0000, 16'h5A5A, 16'hFF00);
    cyc(1, 16'h0005, 16'h1111, 16'h0000);
    check("ram0", bus.mem_read_data, 16'h5A5A);
    cyc(1, 16'h0005, 16'h1234, 16'h0005);
    check("ram_read_first", bus.mem_read_data, 16'h1111);
    cyc(0, 16'h0000, 16'h0000, 16'h0005);
    check("ram_new", bus.mem_read_data, 16'h1234);

    // hole
    cyc(1, 16'h8000, 16'hBEEF, 16'h8000);
    check("hole_read", bus.mem_read_data, 16'h0000);
    cyc(0, 16'h0000, 16'h0000, 16'h0000);
    check("ram0_kept", bus.mem_read_data, 16'h5A5A);
    cyc(1, 16'hFF04, 16'h7777, 16'hFF04);
    check("mmio_other", bus.mem_read_data, 16'h0000);

    // compare / IRQ
    cyc(1, 16'hFF01, 16'h0010, 16'hFF01);
    check("cmp_reset", bus.mem_read_data, 16'h0000);
    cyc(1, 16'hFF00, 16'hFFFF, 16'hFF01);
    check("cmp_written", bus.mem_read_data, 16'h0010);
    cyc(1, 16'hFF02, 16'h0001, 16'hFF00);
    check("cnt_cleared", bus.mem_read_data, 16'h0000);
    repeat (15) cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("irq_not_yet", bus.irq_flag, 1'b0);
    cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("irq_set", bus.irq_flag, 1'b1);
    repeat (5) cyc(0, 16'h0000, 16'h0000, 16'h0000);
    check("irq_sticky", bus.irq_flag, 1'b1);
    cyc(0, 16'h0000, 16'h0000, 16'hFF02);
    check("ctrl_irq", bus.mem_read_data, 16'h000B);
    cyc(1, 16'hFF02, 16'h0003, 16'hFF02);
    check("irq_w1c", bus.irq_flag, 1'b0);
    cyc(0, 16'h0000, 16'h0000, 16'hFF02);
    check("ctrl_after_w1c", bus.mem_read_data, 16'h0009);

    // counter wrap
    cyc(1, 16'hFF02, 16'h0000, 16'h0000);
    cyc(1, 16'hFF00, 16'h0000, 16'hFF00);
    for (int i = 0; i < 65536; i++) cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("cnt_ffff", bus.mem_read_data, 16'hFFFF);
    cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("cnt_wrap", bus.mem_read_data, 16'h0000);

    // FIFO overflow and ordered drain
    bus.tx_ready = 0;
    for (int i = 0; i < 9; i++) cyc(1, 16'hFF03, 16'(16'h0041 + i), 16'hFF02);
    cyc(0, 16'h0000, 16'h0000, 16'hFF02);
    check("fifo_full_ctrl", bus.mem_read_data & 16'h01FC, 16'h0184);
    check("fifo_head", bus.tx_data, 8'h41);
    bus.tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", bus.tx_data, 8'(8'h41 + i));
      cyc(0, 16'h0000, 16'h0000, 16'h0000);
    end
    check("drained", bus.tx_valid, 1'b0);

    // full + push with pop in the same cycle
    bus.tx_ready = 0;
    cyc(1, 16'hFF02, 16'h0100, 16'h0000);
    for (int i = 0; i < 8; i++) cyc(1, 16'hFF03, 16'(16'h0050 + i), 16'h0000);
    bus.tx_ready = 1;
    cyc(1, 16'hFF03, 16'h0058, 16'hFF02);
    check("full_pre", bus.mem_read_data & 16'h01FC, 16'h0084);
    bus.tx_ready = 0;
    cyc(0, 16'h0000, 16'h0000, 16'hFF02);
    check("full_push_pop", bus.mem_read_data & 16'h01FC, 16'h0084);
    check("head_after", bus.tx_data, 8'h51);

    // reset in the middle of a transfer
    bus.tx_ready = 1;
    #2 rst = 1;
    #1;
    check("midrst_rdata", bus.mem_read_data, 16'h0000);
    check("midrst_txvalid", bus.tx_valid, 1'b0);
    check("midrst_txdata", bus.tx_data, 8'h00);
    check("midrst_irq", bus.irq_flag, 1'b0);
    @(posedge clk); #1 rst = 0;
    cyc(0, 16'h0000, 16'h0000, 16'hFF00);
    check("cnt_after_rst", bus.mem_read_data, 16'h0000);
    cyc(0, 16'h0000, 16'h0000, 16'hFF02);
    check("ctrl_after_rst", bus.mem_read_data, 16'h0008);
    cyc(0, 16'h0000, 16'h0000, 16'h0005);
    check("ram_survives_rst", bus.mem_read_data, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
